// File: rtl/waveform_trig_scope.sv
// Triggered scope: decimated capture into a ring buffer, level/slope trigger with pre-trigger history, trace drawing; WAVE_TRIG_MARKER_EN adds trigger markers.
// Display latency 2 clk from coordinates to pixel_out; no backpressure, sample strobes are never stalled.
module waveform_trig_scope #(
  parameter int SAMPLE_W = 10,
  parameter int DEPTH    = 1280,
  parameter int ADDR_W   = 11,
  parameter int PRETRIG  = 320,
  parameter int Y_BOTTOM = 1023,
  parameter int Y_SHIFT  = 0,
  parameter int TIMEOUT  = 20000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [3:0]          decim,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_rising,
  input  logic                auto_mode,
  input  logic                single_shot,
  input  logic                arm,
  input  logic                freeze,
  input  logic                frame_end,
  input  logic [11:0]         horz_coord,
  input  logic [11:0]         vert_coord,
  input  logic [11:0]         wave_color,
  output logic [11:0]         pixel_out,
  output logic                capturing,
  output logic                triggered,
  output logic                trig_forced
);

  localparam int POST_N  = DEPTH - PRETRIG - 1;
  localparam int CNT_MAX = (TIMEOUT > DEPTH) ? TIMEOUT : DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_HOLD} state_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   addr1_t;

  state_t               state, state_nxt;
  logic [3:0]           dec_cnt;
  cnt_t                 cnt;
  addr_t                wr_ptr, trig_ptr, rd_addr;
  logic [SAMPLE_W-1:0]  prev, rd_dat;
  logic                 prev_vld, shown;
  logic [SAMPLE_W-1:0]  mem [DEPTH];

  logic cap_st, accept, trig_hit, timeout_hit, fire, restart;

  assign cap_st      = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
  assign accept      = cap_st && sample_en && (dec_cnt == decim);
  assign trig_hit    = prev_vld && (trig_rising ? (prev < trig_level && trig_level <= sample_in)
                                                : (prev >= trig_level && trig_level > sample_in));
  assign timeout_hit = auto_mode && (cnt == cnt_t'(TIMEOUT - 1));
  assign fire        = (state == S_ARMED) && accept && (trig_hit || timeout_hit);
  assign restart     = !freeze && (single_shot ? arm : frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FILL;
      S_FILL:  if (accept && cnt == cnt_t'(PRETRIG - 1)) state_nxt = S_ARMED;
      S_ARMED: if (fire) state_nxt = (POST_N == 0) ? S_HOLD : S_POST;
      S_POST:  if (accept && cnt == cnt_t'(POST_N - 1)) state_nxt = S_HOLD;
      S_HOLD:  if (restart) state_nxt = S_FILL;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capturing = cap_st;
    triggered = (state == S_POST) || (state == S_HOLD);
  end

  // One counter serves FILL (pre-trigger), ARMED (timeout) and POST; it restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt     <= '0;
      cnt         <= '0;
      wr_ptr      <= '0;
      trig_ptr    <= '0;
      prev        <= '0;
      prev_vld    <= 1'b0;
      trig_forced <= 1'b0;
      shown       <= 1'b0;
    end else begin
      if (!cap_st)        dec_cnt <= '0;
      else if (sample_en) dec_cnt <= (dec_cnt >= decim) ? 4'd0 : dec_cnt + 4'd1;

      if (state != state_nxt) cnt <= '0;
      else if (accept)        cnt <= cnt + cnt_t'(1);

      if (accept) wr_ptr <= (wr_ptr == addr_t'(DEPTH - 1)) ? '0 : wr_ptr + addr_t'(1);

      if (!cap_st) begin
        prev_vld <= 1'b0;
      end else if (accept) begin
        prev     <= sample_in;
        prev_vld <= 1'b1;
      end

      if (fire) begin
        trig_ptr    <= wr_ptr;
        trig_forced <= !trig_hit;
      end

      if (state == S_HOLD) shown <= 1'b1;
    end
  end

  // Column 0 maps to PRETRIG samples before the trigger; both additions stay below 2*DEPTH.
  addr1_t base_sum, rd_sum;
  addr_t  base, col_off;
  always_comb begin
    base_sum = addr1_t'(trig_ptr) + addr1_t'(DEPTH - PRETRIG);
    base     = (base_sum >= addr1_t'(DEPTH)) ? addr_t'(base_sum - addr1_t'(DEPTH)) : addr_t'(base_sum);
    col_off  = ({1'b0, horz_coord} < 13'(DEPTH)) ? addr_t'(horz_coord) : '0;
    rd_sum   = addr1_t'(base) + addr1_t'(col_off);
    rd_addr  = (rd_sum >= addr1_t'(DEPTH)) ? addr_t'(rd_sum - addr1_t'(DEPTH)) : addr_t'(rd_sum);
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= sample_in;
    rd_dat <= mem[rd_addr];
  end

  logic [11:0] h1, v1, y, yp, y_prev, y_lo, y_hi, pix_nxt;
  logic        in_cols, trace_on;

  always_comb begin
    y        = 12'(Y_BOTTOM) - 12'(rd_dat >> Y_SHIFT);
    yp       = (h1 == 12'd0) ? y : y_prev;
    y_lo     = (y < yp) ? y : yp;
    y_hi     = (y < yp) ? yp : y;
    in_cols  = {1'b0, h1} < 13'(DEPTH);
    trace_on = shown && in_cols && (v1 >= y_lo) && (v1 <= y_hi);
    pix_nxt  = 12'h000;
    if (trace_on) pix_nxt = wave_color;
`ifdef WAVE_TRIG_MARKER_EN
    else if (shown && h1 == 12'(PRETRIG)) pix_nxt = 12'h0F0;
    else if (shown && in_cols && v1 == 12'(Y_BOTTOM) - 12'(trig_level >> Y_SHIFT)) pix_nxt = 12'h00F;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1        <= '0;
      v1        <= '0;
      y_prev    <= '0;
      pixel_out <= '0;
    end else begin
      h1        <= horz_coord;
      v1        <= vert_coord;
      y_prev    <= y;
      pixel_out <= pix_nxt;
    end
  end

endmodule

// File: tb/tb_waveform_trig_scope.sv
// Directed bench for waveform_trig_scope using a short record (DEPTH=32, PRETRIG=8, TIMEOUT=16).
module tb_waveform_trig_scope;

  localparam logic [11:0] WC = 12'hABC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_en;
  logic [9:0]  sample_in;
  logic [3:0]  decim;
  logic [9:0]  trig_level;
  logic        trig_rising, auto_mode, single_shot, arm, freeze, frame_end;
  logic [11:0] horz_coord, vert_coord, wave_color;
  logic [11:0] pixel_out;
  logic        capturing, triggered, trig_forced;

  int total = 0;
  int passed = 0;

  typedef struct {
    int          col;
    int          row;
    logic [11:0] exp;
  } vec_t;

  vec_t tab_ramp [11];
  vec_t tab_dec  [7];
  vec_t tab_step [8];

  waveform_trig_scope #(
    .SAMPLE_W(10), .DEPTH(32), .ADDR_W(5), .PRETRIG(8),
    .Y_BOTTOM(1023), .Y_SHIFT(0), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .sample_in(sample_in),
    .decim(decim), .trig_level(trig_level), .trig_rising(trig_rising),
    .auto_mode(auto_mode), .single_shot(single_shot), .arm(arm), .freeze(freeze),
    .frame_end(frame_end), .horz_coord(horz_coord), .vert_coord(vert_coord),
    .wave_color(wave_color), .pixel_out(pixel_out), .capturing(capturing),
    .triggered(triggered), .trig_forced(trig_forced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic send(input logic [9:0] v);
    sample_in = v;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Scan the previous column then the target column, and sample two clocks later.
  task automatic pix(input int c, input int r, input logic [11:0] exp, input string nm);
    horz_coord = 12'((c == 0) ? 0 : c - 1);
    vert_coord = 12'(r);
    @(negedge clk);
    horz_coord = 12'(c);
    @(negedge clk);
    @(negedge clk);
    chk(nm, 32'(pixel_out), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; sample_in = '0; decim = '0; trig_level = '0;
    trig_rising = 1'b1; auto_mode = 1'b0; single_shot = 1'b0; arm = 1'b0;
    freeze = 1'b0; frame_end = 1'b0; horz_coord = '0; vert_coord = '0; wave_color = WC;

    // Ramp 4k: column c shows sample 120+c, y = 543-4c.
    tab_ramp[0]  = '{8, 511, WC};   tab_ramp[1]  = '{8, 515, WC};
    tab_ramp[2]  = '{8, 510, 12'h000}; tab_ramp[3] = '{8, 516, 12'h000};
    tab_ramp[4]  = '{0, 543, WC};   tab_ramp[5]  = '{0, 542, 12'h000};
    tab_ramp[6]  = '{0, 544, 12'h000}; tab_ramp[7] = '{31, 419, WC};
    tab_ramp[8]  = '{31, 424, 12'h000}; tab_ramp[9] = '{20, 463, WC};
    tab_ramp[10] = '{32, 419, 12'h000};
    // decim=3, strobe k = 5k: column c shows accepted j=15+c, value 315+20c, y = 708-20c.
    tab_dec[0] = '{1, 688, WC};      tab_dec[1] = '{1, 708, WC};
    tab_dec[2] = '{1, 709, 12'h000}; tab_dec[3] = '{1, 687, 12'h000};
    tab_dec[4] = '{31, 88, WC};      tab_dec[5] = '{8, 548, WC};
    tab_dec[6] = '{8, 569, 12'h000};
    // Step 900 -> 100 at the trigger column: rows 123..923.
    tab_step[0] = '{8, 123, WC};      tab_step[1] = '{8, 923, WC};
    tab_step[2] = '{8, 500, WC};      tab_step[3] = '{8, 122, 12'h000};
    tab_step[4] = '{8, 924, 12'h000}; tab_step[5] = '{9, 923, WC};
    tab_step[6] = '{9, 922, 12'h000}; tab_step[7] = '{40, 500, 12'h000};

    repeat (2) @(negedge clk);
    chk("rst_pixel", 32'(pixel_out), 32'h0);
    chk("rst_capturing", 32'(capturing), 32'h0);
    chk("rst_triggered", 32'(triggered), 32'h0);
    chk("rst_trig_forced", 32'(trig_forced), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("fill_after_rst", 32'(capturing), 32'h1);

    single_shot = 1'b1; trig_level = 10'd512; trig_rising = 1'b1;
    for (int k = 0; k < 31; k++) send(10'((4 * k) % 1024));
    pix(0, 927, 12'h000, "gate_before_hold");
    for (int k = 31; k < 152; k++) begin
      send(10'((4 * k) % 1024));
      if (k == 127) chk("ramp_not_trig_127", 32'(triggered), 32'h0);
      if (k == 128) chk("ramp_trig_128", 32'(triggered), 32'h1);
      if (k == 150) chk("ramp_post_150", 32'(capturing), 32'h1);
      if (k == 151) chk("ramp_hold_151", 32'(capturing), 32'h0);
    end
    chk("ramp_not_forced", 32'(trig_forced), 32'h0);
    repeat (5) send(10'd0);
    for (int i = 0; i < 11; i++)
      pix(tab_ramp[i].col, tab_ramp[i].row, tab_ramp[i].exp, $sformatf("ramp_pix[%0d]", i));

    pulse_frame_end();
    chk("ss_frame_end_stay", 32'(triggered), 32'h1);
    freeze = 1'b1;
    pulse_arm();
    freeze = 1'b0;
    chk("ss_arm_frozen_stay", 32'(triggered), 32'h1);
    decim = 4'd3; auto_mode = 1'b1; trig_level = 10'd1000;
    pulse_arm();
    chk("ss_arm_restart_cap", 32'(capturing), 32'h1);
    chk("ss_arm_restart_trg", 32'(triggered), 32'h0);

    for (int k = 0; k < 188; k++) begin
      send(10'(5 * k));
      if (k == 91)  chk("dec_not_trig", 32'(triggered), 32'h0);
      if (k == 95)  chk("dec_forced_trig", 32'(triggered), 32'h1);
      if (k == 95)  chk("dec_forced_flag", 32'(trig_forced), 32'h1);
      if (k == 186) chk("dec_post_186", 32'(capturing), 32'h1);
      if (k == 187) chk("dec_hold_187", 32'(capturing), 32'h0);
    end
    for (int i = 0; i < 7; i++)
      pix(tab_dec[i].col, tab_dec[i].row, tab_dec[i].exp, $sformatf("dec_pix[%0d]", i));

    single_shot = 1'b0; decim = 4'd0; auto_mode = 1'b0;
    trig_level = 10'd512; trig_rising = 1'b0;
    freeze = 1'b1;
    pulse_frame_end();
    freeze = 1'b0;
    chk("fe_frozen_stay", 32'(triggered), 32'h1);
    pulse_frame_end();
    chk("fe_restart", 32'(capturing), 32'h1);

    repeat (9) send(10'd900);
    chk("step_not_trig", 32'(triggered), 32'h0);
    chk("step_forced_kept", 32'(trig_forced), 32'h1);
    send(10'd100);
    chk("step_fall_trig", 32'(triggered), 32'h1);
    chk("step_forced_clr", 32'(trig_forced), 32'h0);
    repeat (23) send(10'd100);
    chk("step_hold", 32'(capturing), 32'h0);
    for (int i = 0; i < 8; i++)
      pix(tab_step[i].col, tab_step[i].row, tab_step[i].exp, $sformatf("step_pix[%0d]", i));

    trig_rising = 1'b1; auto_mode = 1'b1;
    pulse_frame_end();
    horz_coord = 12'd8; vert_coord = 12'd923;
    repeat (23) send(10'd100);
    chk("const_armed_wait", 32'(triggered), 32'h0);
    send(10'd100);
    chk("const_forced_trig", 32'(triggered), 32'h1);
    chk("const_forced_flag", 32'(trig_forced), 32'h1);
    repeat (3) send(10'd100);
    chk("const_live_pixel", 32'(pixel_out), 32'(WC));

    rst_n = 1'b0;
    #1;
    chk("mid_rst_pixel", 32'(pixel_out), 32'h0);
    chk("mid_rst_capturing", 32'(capturing), 32'h0);
    chk("mid_rst_triggered", 32'(triggered), 32'h0);
    chk("mid_rst_forced", 32'(trig_forced), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_fill", 32'(capturing), 32'h1);
    chk("mid_rst_pixel_gate", 32'(pixel_out), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
